st_packet_channel_arbiter: RTL and testbench

- Packet-locked round-robin arbiter that merges NUM_CH single-channel Avalon-ST byte streams into one channelized stream.
- Sits upstream of the console master's bytes-to-packets channel adapter and drives its in_channel.
- Holds a grant for a whole packet (SOP to EOP) so packets never interleave.
- Registers the output beat so the merged stream meets timing into the adapter.

---
 rtl/st_packet_channel_arbiter_pkg.sv | 22 ++
 rtl/st_packet_channel_arbiter_rr_picker.sv | 30 +++
 rtl/st_packet_channel_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_st_packet_channel_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_packet_channel_arbiter_pkg.sv
// Shared types and helpers for the packet-locked channel arbiter and its picker.
package st_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int TIMEOUT_CYC_DEF = 1024;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/st_packet_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
module st_arb_rr_picker
    import st_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic              o_found,
    output logic [IDX_W-1:0]  o_idx
);

    // scan from i_last+1 upward, first hit wins
    always_comb begin
        int               c_v;
        logic [IDX_W-1:0] idx_v;
        logic             hit_v;
        o_found = 1'b0;
        o_idx   = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_CH; k++) begin
            c_v     = (int'(i_last) + k) % NUM_CH;
            idx_v   = IDX_W'(c_v);
            hit_v   = i_req[idx_v] & ~o_found;
            o_idx   = hit_v ? idx_v : o_idx;
            o_found = o_found | hit_v;
        end
    end

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Packet-locked round-robin merge of NUM_CH Avalon-ST streams into one channelized stream.
// Optional idle-lock watchdog enabled by defining ST_ARB_PKT_TIMEOUT_EN.
module st_packet_channel_arbiter
    import st_arb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 8,
    parameter int CH_W        = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_startofpacket,
    input  logic [NUM_CH-1:0]        in_endofpacket,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     busy,
    output logic                     err_orphan,
    output logic                     err_timeout
);

    localparam int               IDX_W    = ch_idx_w(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

    if (NUM_CH < 2 || NUM_CH > 16 || CH_W < IDX_W || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("st_packet_channel_arbiter: illegal parameter combination");
    end

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_found;
    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_orphan_vec;
    logic                w_orphan;
    logic                w_take;
    logic                w_acc;
    logic                w_acc_eop;
    logic                w_release;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_gdata;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_channel;
    logic                r_out_sop;
    logic                r_out_eop;
    logic                r_err_orphan;

    assign w_req = in_valid & in_startofpacket;

    st_arb_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state: leave LOCKED on an accepted EOP or a watchdog release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = LOCKED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // handshake outputs: granted channel follows the output slot, orphans are swallowed
    always_comb begin
        w_take       = out_ready | ~r_out_valid;
        w_orphan_vec = in_valid & ~in_startofpacket;
        in_ready     = w_orphan_vec;
        w_acc_eop    = in_endofpacket[r_grant];
        w_gdata      = in_data[int'(r_grant)*DATA_W +: DATA_W];
        if (r_state == LOCKED) begin
            w_orphan_vec[r_grant] = 1'b0;
            in_ready[r_grant]     = w_take;
            w_acc                 = in_valid[r_grant] & w_take;
        end else begin
            w_acc = 1'b0;
        end
        w_orphan  = |w_orphan_vec;
        w_release = (w_acc & w_acc_eop) | w_timeout;
    end

`ifdef ST_ARB_PKT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err_timeout;

    // stall cycles of the granted channel; the cycle that would reach the limit releases
    assign w_timeout = (r_state == LOCKED) & ~in_valid[r_grant] &
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // watchdog counter and its sticky flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt      <= {TO_W{1'b0}};
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state != LOCKED || w_acc || w_timeout) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else if (!in_valid[r_grant]) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // grant and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= {IDX_W{1'b0}};
            r_last  <= LAST_RST;
        end else begin
            if (r_state == IDLE && w_pick_found) begin
                r_grant <= w_pick_idx;
            end
            if (w_release) begin
                r_last <= r_grant;
            end
        end
    end

    // output slot: load on accept, drain on out_ready, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= {DATA_W{1'b0}};
            r_out_channel <= {CH_W{1'b0}};
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
        end else if (w_acc) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_gdata;
            r_out_channel <= CH_W'(r_grant);
            r_out_sop     <= in_startofpacket[r_grant];
            r_out_eop     <= w_acc_eop;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    // sticky orphan flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_orphan <= 1'b0;
        end else if (w_orphan) begin
            r_err_orphan <= 1'b1;
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_channel       = r_out_channel;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign busy              = (r_state == LOCKED);
    assign err_orphan        = r_err_orphan;

endmodule

// File: tb/tb_st_packet_channel_arbiter.sv
// Self-checking bench: per-cycle behavioural model plus directed and random packet traffic.
module tb_st_packet_channel_arbiter;

    localparam int N = 3;
`ifdef ST_ARB_PKT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic           clk, reset;
    logic [N-1:0]   in_valid, in_ready, in_sop, in_eop;
    logic [N*8-1:0] in_data;
    logic           out_valid, out_ready, out_sop, out_eop, busy, err_orphan, err_timeout;
    logic [7:0]     out_data, out_channel;

    st_packet_channel_arbiter #(.NUM_CH(N), .DATA_W(8), .CH_W(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .busy(busy), .err_orphan(err_orphan), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic s; logic e; int gap; } beat_t;
    typedef struct { logic [7:0] d; logic s; logic e; } sb_t;

    beat_t      srcq [N][$];
    int         gapc [N];
    bit         pres [N];
    sb_t        sbq  [N][$];
    logic [7:0] genq [N][$];

    int         m_owner, m_last, m_tcnt, m_ch;
    bit         m_slot_v, m_s, m_e, m_orph, m_to;
    logic [7:0] m_d;

    int         log_cyc[$], log_ch[$];
    logic [7:0] log_d[$];
    int         cyc, lo_from, lo_to, ordy_pct;
    logic [7:0] hold_d;
    bit         saw_orph_rdy;
    int         n_checks, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic s, input logic e, input int gap);
        beat_t b;
        b.d = d; b.s = s; b.e = e; b.gap = gap;
        return b;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_tcnt = 0; m_slot_v = 0;
        m_d = 8'h00; m_ch = 0; m_s = 0; m_e = 0; m_orph = 0; m_to = 0;
        for (int i = 0; i < N; i++) sbq[i].delete();
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && srcq[i].size() > 0) begin
                if (gapc[i] >= srcq[i][0].gap) pres[i] = 1;
                else gapc[i]++;
            end
            in_valid[i] = pres[i];
            in_sop[i]   = pres[i] ? srcq[i][0].s : 1'b0;
            in_eop[i]   = pres[i] ? srcq[i][0].e : 1'b0;
            in_data[i*8 +: 8] = pres[i] ? srcq[i][0].d : 8'h00;
        end
        out_ready = (cyc >= lo_from && cyc <= lo_to) ? 1'b0 : ($urandom_range(99) < ordy_pct);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete(); genq[i].delete(); gapc[i] = 0; pres[i] = 0;
        end
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cyc = 0; lo_from = -1; lo_to = -2; ordy_pct = 100; saw_orph_rdy = 0;
        log_cyc.delete(); log_ch.delete(); log_d.delete();
    endtask

    // One clock: compare DUT to the model, advance the model, then move the sources.
    task automatic step();
        logic [N-1:0] er;
        bit   [N-1:0] hs;
        bit           found;
        int           c, g;
        sb_t          t;
        @(negedge clk);
        chk("out_valid", out_valid, m_slot_v);
        if (m_slot_v) begin
            chk("out_data", out_data, m_d);
            chk("out_channel", out_channel, m_ch);
            chk("out_sop", out_sop, m_s);
            chk("out_eop", out_eop, m_e);
        end
        chk("busy", busy, m_owner >= 0);
        chk("err_orphan", err_orphan, m_orph);
        chk("err_timeout", err_timeout, m_to);
        for (int i = 0; i < N; i++)
            er[i] = (m_owner == i) ? (out_ready || !m_slot_v) : (in_valid[i] && !in_sop[i]);
        chk("in_ready", in_ready, er);
        if (in_valid[1] && !in_sop[1] && in_ready[1] && m_owner == 0) saw_orph_rdy = 1;
        if (cyc >= lo_from && cyc <= lo_to) begin
            chk("hold_data", out_data, 8'h31);
            chk("hold_ch1_ready", in_ready[1], 1'b0);
        end
        if (out_valid && out_ready) begin
            log_cyc.push_back(cyc); log_ch.push_back(out_channel); log_d.push_back(out_data);
            if (out_channel < N && sbq[out_channel].size() > 0) begin
                t = sbq[out_channel].pop_front();
                chk("sb_data", out_data, t.d);
                chk("sb_sop", out_sop, t.s);
                chk("sb_eop", out_eop, t.e);
            end else begin
                chk("sb_unexpected_beat", out_channel, 8'hFF);
            end
        end
        for (int i = 0; i < N; i++) begin
            hs[i] = in_valid[i] && er[i];
            if (i != m_owner && in_valid[i] && !in_sop[i]) m_orph = 1;
        end
        if (m_owner < 0) begin
            if (out_ready) m_slot_v = 0;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && in_valid[c] && in_sop[c]) begin
                    found = 1; m_owner = c; m_tcnt = 0;
                end
            end
        end else if (hs[m_owner]) begin
            g = m_owner;
            m_slot_v = 1; m_d = in_data[g*8 +: 8]; m_ch = g; m_s = in_sop[g]; m_e = in_eop[g];
            t.d = m_d; t.s = m_s; t.e = m_e;
            sbq[g].push_back(t);
            m_tcnt = 0;
            if (m_e) begin m_last = g; m_owner = -1; end
        end else begin
            if (out_ready) m_slot_v = 0;
            if (!in_valid[m_owner]) m_tcnt++;
`ifdef ST_ARB_PKT_TIMEOUT_EN
            if (m_tcnt >= TO) begin m_last = m_owner; m_owner = -1; m_to = 1; m_tcnt = 0; end
`endif
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(srcq[i].pop_front());
                pres[i] = 0; gapc[i] = 0;
            end
        end
        cyc++;
        drive_sources();
    endtask

    function automatic bit all_idle();
        bit r;
        r = !m_slot_v && m_owner < 0;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) r = 0;
        return r;
    endfunction

    task automatic run(input int maxc);
        int n;
        n = 0;
        while (!all_idle() && n < maxc) begin
            step();
            n++;
        end
        chk("drain_budget", n < maxc, 1'b1);
    endtask

    initial begin
        int exp_c1[6];
        int total, len, c;
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1;

        // Scenario 1: reset state, then ch0 and ch1 3-beat packets at cycle 0
        do_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_channel", out_channel, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {err_orphan, err_timeout, out_sop, out_eop}, 4'h0);
        for (int b = 0; b < 3; b++) begin
            srcq[0].push_back(mk(8'h10 + 8'(b), b == 0, b == 2, 0));
            srcq[1].push_back(mk(8'h20 + 8'(b), b == 0, b == 2, 0));
        end
        drive_sources();
        run(100);
        exp_c1 = '{2, 3, 4, 6, 7, 8};
        chk("s1_beats", log_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_d.size()) begin
                chk("s1_cycle", log_cyc[i], exp_c1[i]);
                chk("s1_channel", log_ch[i], (i < 3) ? 0 : 1);
                chk("s1_data", log_d[i], (i < 3) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 3));
            end
        end

        // Scenario 2: ch1 single-beat packets back to back
        do_reset();
        srcq[1].push_back(mk(8'hA5, 1, 1, 0));
        srcq[1].push_back(mk(8'h5A, 1, 1, 0));
        drive_sources();
        run(100);
        chk("s2_beats", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("s2_cyc0", log_cyc[0], 2);
            chk("s2_cyc1", log_cyc[1], 4);
            chk("s2_d0", log_d[0], 8'hA5);
            chk("s2_d1", log_d[1], 8'h5A);
            chk("s2_ch", log_ch[0] + log_ch[1], 2);
        end

        // Scenario 3: out_ready low for 5 cycles mid-packet, ch1 waiting
        do_reset();
        for (int b = 0; b < 6; b++) srcq[0].push_back(mk(8'h30 + 8'(b), b == 0, b == 5, 0));
        srcq[1].push_back(mk(8'h40, 1, 0, 0));
        srcq[1].push_back(mk(8'h41, 0, 1, 0));
        lo_from = 3; lo_to = 7;
        drive_sources();
        run(100);
        chk("s3_beats", log_d.size(), 8);
        for (int i = 0; i < 6; i++)
            if (i < log_d.size()) chk("s3_data", log_d[i], 8'h30 + 8'(i));

        // Scenario 4: orphan beat on ch1 while ch0 is locked
        do_reset();
        for (int b = 0; b < 4; b++) srcq[0].push_back(mk(8'h50 + 8'(b), b == 0, b == 3, 0));
        srcq[1].push_back(mk(8'h33, 0, 0, 2));
        drive_sources();
        run(100);
        chk("s4_orphan_ready", saw_orph_rdy, 1'b1);
        chk("s4_err_orphan", err_orphan, 1'b1);
        chk("s4_beats", log_d.size(), 4);
        for (int i = 0; i < log_d.size(); i++) chk("s4_no_ch1", log_ch[i], 0);

        // Scenario 5: asynchronous reset on beat 2 of a 4-beat packet
        do_reset();
        for (int b = 0; b < 4; b++) srcq[0].push_back(mk(8'h60 + 8'(b), b == 0, b == 3, 0));
        drive_sources();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("s5_async_valid", out_valid, 1'b0);
        chk("s5_async_data", out_data, 8'h00);
        chk("s5_async_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        void'(srcq[0].pop_front());
        pres[0] = 0; gapc[0] = 0;
        log_cyc.delete(); log_ch.delete(); log_d.delete();
        drive_sources();
        run(100);
        chk("s5_no_output", log_d.size(), 0);
        chk("s5_err_orphan", err_orphan, 1'b1);

`ifdef ST_ARB_PKT_TIMEOUT_EN
        // Scenario 6: ch0 stalls after SOP, watchdog releases and ch1 follows
        do_reset();
        srcq[0].push_back(mk(8'h70, 1, 0, 0));
        srcq[0].push_back(mk(8'h71, 0, 1, 40));
        srcq[1].push_back(mk(8'h80, 1, 1, 0));
        drive_sources();
        run(200);
        chk("s6_err_timeout", err_timeout, 1'b1);
        chk("s6_beats", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("s6_ch1_data", log_d[1], 8'h80);
            chk("s6_ch1_cycle", log_cyc[1], 20);
        end
`endif

        // Scenario 7: random packets, gaps, orphans and backpressure
        do_reset();
        total = 0;
        for (int ch = 0; ch < N; ch++) begin
            for (int p = 0; p < 20; p++) begin
                if ($urandom_range(9) == 0)
                    srcq[ch].push_back(mk(8'($urandom_range(255)), 0, 0, $urandom_range(2)));
                len = $urandom_range(5, 1);
                for (int b = 0; b < len; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(255));
                    srcq[ch].push_back(mk(d, b == 0, b == len - 1,
                                          ($urandom_range(9) < 3) ? $urandom_range(3) : 0));
                    genq[ch].push_back(d);
                    total++;
                end
            end
        end
        ordy_pct = 70;
        drive_sources();
        run(20000);
        chk("rand_count", log_d.size(), total);
        for (int j = 0; j < log_d.size(); j++) begin
            c = log_ch[j];
            if (c < N && genq[c].size() > 0) chk("rand_order", log_d[j], genq[c].pop_front());
            else chk("rand_extra", c, 255);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
